// File: rtl/vga_pattern_scheduler.sv
`default_nettype none
// ============================================================================
// Module : vga_pattern_scheduler
// Debounced manual / timed auto selection among three pattern sources,
// with every switch aligned to a frame start.
// Rev    : 1.0
// ============================================================================
module vga_pattern_scheduler #(
    parameter int DEBOUNCE_CLKS = 250_000,
    parameter int DWELL_FRAMES  = 300
) (
    input  logic       i_clk,
    input  logic       i_reset,
    input  logic       i_frame_start,
    input  logic       i_active,
    input  logic       i_next,
    input  logic       i_auto,
    input  logic [8:0] i_rgb0,
    input  logic [8:0] i_rgb1,
    input  logic [8:0] i_rgb2,
    output logic [2:0] o_red,
    output logic [2:0] o_green,
    output logic [2:0] o_blue,
    output logic [1:0] o_sel,
    output logic       o_switch
);

    localparam int              CW          = $clog2(DEBOUNCE_CLKS + 1);
    localparam logic [CW-1:0]   c_deb_last  = CW'(DEBOUNCE_CLKS - 1);
    localparam logic [CW-1:0]   c_one       = CW'(1);
    localparam logic [15:0]     c_dwell_last = 16'(DWELL_FRAMES - 1);

    typedef enum logic [1:0] {
        S_IDLE         = 2'd0,
        S_PRESS_WAIT   = 2'd1,
        S_HELD         = 2'd2,
        S_RELEASE_WAIT = 2'd3
    } deb_state_t;

    deb_state_t    r_state;
    logic [CW-1:0] r_cnt;
    logic          r_sync1;
    logic          r_sync2;
    logic          r_pending;
    logic [15:0]   r_dwell;
    logic          w_accept;
    logic          w_fire;
    logic          w_adv;
    logic [8:0]    w_pix;

    // Entering a wait state counts the sample that caused the entry.
    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
            r_state <= S_IDLE;
            r_cnt   <= '0;
        end else begin
            r_sync1 <= i_next;
            r_sync2 <= r_sync1;
            case (r_state)
                S_IDLE: begin
                    if (r_sync2) begin
                        r_state <= S_PRESS_WAIT;
                        r_cnt   <= c_one;
                    end
                end
                S_PRESS_WAIT: begin
                    if (!r_sync2) begin
                        r_state <= S_IDLE;
                        r_cnt   <= '0;
                    end else if (r_cnt >= c_deb_last) begin
                        r_state <= S_HELD;
                        r_cnt   <= '0;
                    end else begin
                        r_cnt <= r_cnt + c_one;
                    end
                end
                S_HELD: begin
                    if (!r_sync2) begin
                        r_state <= S_RELEASE_WAIT;
                        r_cnt   <= c_one;
                    end
                end
                S_RELEASE_WAIT: begin
                    if (r_sync2) begin
                        r_state <= S_HELD;
                        r_cnt   <= '0;
                    end else if (r_cnt >= c_deb_last) begin
                        r_state <= S_IDLE;
                        r_cnt   <= '0;
                    end else begin
                        r_cnt <= r_cnt + c_one;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_cnt   <= '0;
                end
            endcase
        end
    end

    assign w_accept = (r_state == S_PRESS_WAIT) && r_sync2 && (r_cnt >= c_deb_last);
    assign w_fire   = i_auto && i_frame_start && (r_dwell == c_dwell_last);
    assign w_adv    = i_frame_start && (r_pending || w_fire);

    always_comb begin
        w_pix = 9'd0;
        case (o_sel)
            2'd0:    w_pix = i_rgb0;
            2'd1:    w_pix = i_rgb1;
            2'd2:    w_pix = i_rgb2;
            default: w_pix = 9'd0;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            o_sel     <= 2'd0;
            o_switch  <= 1'b0;
            o_red     <= 3'd0;
            o_green   <= 3'd0;
            o_blue    <= 3'd0;
            r_pending <= 1'b0;
            r_dwell   <= 16'd0;
        end else begin
            o_switch <= 1'b0;
            // Index 3 is illegal: recover to 0 at once rather than wait for a frame.
            if (o_sel == 2'd3) begin
                o_sel    <= 2'd0;
                o_switch <= 1'b1;
            end else if (w_adv) begin
                o_sel    <= (o_sel == 2'd2) ? 2'd0 : o_sel + 2'd1;
                o_switch <= 1'b1;
            end

            if (w_accept) begin
                r_pending <= 1'b1;
            end else if (w_adv) begin
                r_pending <= 1'b0;
            end

            if (!i_auto || w_adv) begin
                r_dwell <= 16'd0;
            end else if (i_frame_start) begin
                r_dwell <= r_dwell + 16'd1;
            end

            o_red   <= i_active ? w_pix[8:6] : 3'd0;
            o_green <= i_active ? w_pix[5:3] : 3'd0;
            o_blue  <= i_active ? w_pix[2:0] : 3'd0;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_vga_pattern_scheduler.sv
`default_nettype none
// Bench for vga_pattern_scheduler: random pixel traffic against a frame-level
// model of the selection rules (manual presses, auto dwell, reset).
module tb_vga_pattern_scheduler;
    localparam int DEB   = 4;
    localparam int DWELL = 3;
    localparam int FRAME = 100;

    logic       i_clk = 1'b0;
    logic       i_reset = 1'b0;
    logic       i_frame_start = 1'b0;
    logic       i_active = 1'b0;
    logic       i_next = 1'b0;
    logic       i_auto = 1'b0;
    logic [8:0] i_rgb0 = '0;
    logic [8:0] i_rgb1 = '0;
    logic [8:0] i_rgb2 = '0;
    logic [2:0] o_red, o_green, o_blue;
    logic [1:0] o_sel;
    logic       o_switch;

    int         checks = 0;
    int         errors = 0;
    int         phase = 1;
    int         exp_sel = 0;
    int         m_frames = 0;
    bit         m_pend = 1'b0;
    bit         exp_sw = 1'b0;
    logic [8:0] exp_col = '0;
    bit         rnd_in = 1'b1;

    always #5 i_clk = ~i_clk;

    vga_pattern_scheduler #(.DEBOUNCE_CLKS(DEB), .DWELL_FRAMES(DWELL)) dut (
        .i_clk(i_clk), .i_reset(i_reset), .i_frame_start(i_frame_start),
        .i_active(i_active), .i_next(i_next), .i_auto(i_auto),
        .i_rgb0(i_rgb0), .i_rgb1(i_rgb1), .i_rgb2(i_rgb2),
        .o_red(o_red), .o_green(o_green), .o_blue(o_blue),
        .o_sel(o_sel), .o_switch(o_switch)
    );

    // One clock: drive inputs, step the frame-level model, sample 1 ns after the edge.
    task automatic tick();
        i_frame_start = (phase == 0);
        if (rnd_in) begin
            i_rgb0   = 9'($urandom);
            i_rgb1   = 9'($urandom);
            i_rgb2   = 9'($urandom);
            i_active = ($urandom_range(0, 3) != 0);
        end
        @(posedge i_clk);
        exp_sw = 1'b0;
        if (!i_reset) begin
            exp_sel = 0; m_pend = 1'b0; m_frames = 0; exp_col = '0;
        end else begin
            exp_col = !i_active ? 9'd0 : (exp_sel == 0) ? i_rgb0 : (exp_sel == 1) ? i_rgb1 : i_rgb2;
            if (i_frame_start) begin
                if (m_pend || (i_auto && m_frames + 1 >= DWELL)) begin
                    exp_sel = (exp_sel + 1) % 3; m_pend = 1'b0; m_frames = 0; exp_sw = 1'b1;
                end else if (i_auto) begin
                    m_frames++;
                end
            end
            if (!i_auto) m_frames = 0;
        end
        #1;
        phase = (phase + 1) % FRAME;
    endtask

    task automatic wait_phase(input int p);
        for (int k = 0; k < FRAME && phase != p; k++) tick();
    endtask

    task automatic test_reset();
        i_reset = 1'b0;
        for (int k = 0; k < 3; k++) tick();
        checks++;
        if ({o_sel, o_switch, o_red, o_green, o_blue} !== 12'd0) begin
            errors++;
            $display("FAIL reset_outputs: got sel=%0d sw=%0b rgb=%0d/%0d/%0d want all 0",
                     o_sel, o_switch, o_red, o_green, o_blue);
        end
        i_reset = 1'b1;
    endtask

    task automatic test_colour();
        rnd_in = 1'b0;
        i_active = 1'b1; i_rgb0 = 9'h1FF; i_rgb1 = 9'h000; i_rgb2 = 9'h0AA;
        tick();
        checks++;
        if (o_sel !== 2'd0 || {o_red, o_green, o_blue} !== 9'h1FF) begin
            errors++;
            $display("FAIL colour_white: got sel=%0d rgb=%0d/%0d/%0d want 0 7/7/7", o_sel, o_red, o_green, o_blue);
        end
        i_active = 1'b0;
        tick();
        checks++;
        if ({o_red, o_green, o_blue} !== 9'd0) begin
            errors++;
            $display("FAIL colour_blank: got %0d/%0d/%0d want 0/0/0", o_red, o_green, o_blue);
        end
        rnd_in = 1'b1;
        for (int k = 0; k < 200; k++) begin
            tick();
            checks++;
            if ({o_red, o_green, o_blue} !== exp_col) begin
                errors++;
                $display("FAIL colour_random: got %h want %h", {o_red, o_green, o_blue}, exp_col);
            end
        end
    endtask

    task automatic test_manual_press();
        int start, pulses;
        wait_phase(20);
        start = exp_sel; pulses = 0;
        i_next = 1'b1;
        for (int k = 0; k < 10; k++) begin
            tick();
            checks++;
            if (o_sel !== 2'(start)) begin
                errors++;
                $display("FAIL press_midframe: got sel=%0d want %0d", o_sel, start);
            end
        end
        i_next = 1'b0; m_pend = 1'b1;
        for (int k = 0; k < 130; k++) begin
            tick();
            if (o_switch) pulses++;
            checks++;
            if (o_sel !== 2'(exp_sel) || o_switch !== exp_sw) begin
                errors++;
                $display("FAIL press_advance: got sel=%0d sw=%0b want %0d %0b", o_sel, o_switch, exp_sel, exp_sw);
            end
        end
        checks++;
        if (pulses != 1 || o_sel !== 2'((start + 1) % 3)) begin
            errors++;
            $display("FAIL press_once: got pulses=%0d sel=%0d want 1 %0d", pulses, o_sel, (start + 1) % 3);
        end
    endtask

    task automatic test_hold_no_repeat();
        int pulses;
        wait_phase(20);
        pulses = 0;
        i_next = 1'b1;
        for (int k = 0; k < 260; k++) begin
            if (k == 10) m_pend = 1'b1;
            if (k == 250) i_next = 1'b0;
            tick();
            if (o_switch) pulses++;
            checks++;
            if (o_sel !== 2'(exp_sel) || o_switch !== exp_sw) begin
                errors++;
                $display("FAIL hold: got sel=%0d sw=%0b want %0d %0b", o_sel, o_switch, exp_sel, exp_sw);
            end
        end
        checks++;
        if (pulses != 1) begin
            errors++;
            $display("FAIL hold_repeat: got pulses=%0d want 1", pulses);
        end
    endtask

    task automatic test_bounce();
        bit pat [6] = '{1, 1, 0, 1, 1, 0};
        int start;
        wait_phase(20);
        start = exp_sel;
        for (int k = 0; k < 6; k++) begin
            i_next = pat[k];
            tick();
        end
        for (int k = 0; k < 130; k++) begin
            tick();
            checks++;
            if (o_sel !== 2'(start) || o_switch !== 1'b0) begin
                errors++;
                $display("FAIL bounce: got sel=%0d sw=%0b want %0d 0", o_sel, o_switch, start);
            end
        end
    endtask

    task automatic test_auto_cycle();
        int pulses, prev;
        bit wrap;
        pulses = 0; wrap = 1'b0; prev = o_sel;
        wait_phase(50);
        i_auto = 1'b1;
        for (int k = 0; k < 10 * FRAME; k++) begin
            tick();
            if (o_switch) pulses++;
            if (prev == 2 && o_sel == 2'd0) wrap = 1'b1;
            prev = o_sel;
            checks++;
            if (o_sel !== 2'(exp_sel) || o_switch !== exp_sw) begin
                errors++;
                $display("FAIL auto: got sel=%0d sw=%0b want %0d %0b", o_sel, o_switch, exp_sel, exp_sw);
            end
        end
        checks++;
        if (pulses != 3 || !wrap) begin
            errors++;
            $display("FAIL auto_count: got pulses=%0d wrap=%0b want 3 1", pulses, wrap);
        end
    endtask

    task automatic test_coincide();
        int start, pulses, guard;
        guard = 0;
        while (!(phase == 20 && m_frames == DWELL - 1) && guard < 2000) begin
            tick(); guard++;
        end
        checks++;
        if (guard >= 2000) begin
            errors++;
            $display("FAIL coincide_timeout: got %0d cycles want < 2000", guard);
        end
        start = exp_sel; pulses = 0;
        i_next = 1'b1;
        for (int k = 0; k < 10; k++) tick();
        i_next = 1'b0; m_pend = 1'b1;
        for (int k = 0; k < 130; k++) begin
            tick();
            if (o_switch) pulses++;
        end
        checks++;
        if (pulses != 1 || o_sel !== 2'((start + 1) % 3)) begin
            errors++;
            $display("FAIL coincide: got pulses=%0d sel=%0d want 1 %0d", pulses, o_sel, (start + 1) % 3);
        end
        pulses = 0;
        for (int k = 0; k < 3 * FRAME; k++) begin
            tick();
            if (o_switch) pulses++;
            checks++;
            if (o_sel !== 2'(exp_sel) || o_switch !== exp_sw) begin
                errors++;
                $display("FAIL dwell_restart: got sel=%0d sw=%0b want %0d %0b", o_sel, o_switch, exp_sel, exp_sw);
            end
        end
        checks++;
        if (pulses != 1) begin
            errors++;
            $display("FAIL dwell_count: got pulses=%0d want 1", pulses);
        end
        i_auto = 1'b0;
    endtask

    task automatic test_reset_mid();
        wait_phase(20);
        i_next = 1'b1;
        for (int k = 0; k < 10; k++) tick();
        i_next = 1'b0;
        i_reset = 1'b0;
        #2;
        checks++;
        if ({o_sel, o_switch, o_red, o_green, o_blue} !== 12'd0) begin
            errors++;
            $display("FAIL reset_async: got sel=%0d sw=%0b rgb=%0d/%0d/%0d want all 0",
                     o_sel, o_switch, o_red, o_green, o_blue);
        end
        tick();
        i_reset = 1'b1;
        for (int k = 0; k < 150; k++) begin
            tick();
            checks++;
            if (o_sel !== 2'd0 || o_switch !== 1'b0) begin
                errors++;
                $display("FAIL reset_discard: got sel=%0d sw=%0b want 0 0", o_sel, o_switch);
            end
        end
    endtask

    initial begin
        test_reset();
        test_colour();
        test_manual_press();
        test_hold_no_repeat();
        test_bounce();
        test_auto_cycle();
        test_coincide();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
`default_nettype wire
